// File: rtl/rs_encoder_lfsr.sv
// Systematic byte-serial RS(K+NSYM,K) encoder over GF(2^8) (poly 0x11D, alpha=0x02), division LFSR.
// Latency: each accepted symbol appears on dout one cycle later; NSYM parity symbols follow with no gap.
// Backpressure: none on output; din_ready is low while parity shifts out, high otherwise.

// Combinational GF(2^8) multiplier, reduction by x^8+x^4+x^3+x^2+1.
module gf256_mul (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_p
);
  logic [7:0] w_acc;
  logic [7:0] w_sh;

  // Shift-and-add product: accumulate a*x^k for each set bit of b, reducing as we go.
  always_comb begin
    w_acc = 8'h00;
    w_sh  = i_a;
    for (int k = 0; k < 8; k++) begin
      if (i_b[k]) w_acc = w_acc ^ w_sh;
      w_sh = {w_sh[6:0], 1'b0} ^ (w_sh[7] ? 8'h1D : 8'h00);
    end
    o_p = w_acc;
  end
endmodule

module rs_encoder_lfsr #(
  parameter int K    = 239,
  parameter int NSYM = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,        // asynchronous, active-low
  input  logic [7:0] i_din,
  input  logic       i_din_valid,
  input  logic       i_start,
  output logic       o_din_ready,
  output logic [7:0] o_dout,
  output logic       o_dout_valid,
  output logic       o_dout_sop,
  output logic       o_dout_eop,
  output logic       o_parity_flag,
  output logic       o_abort,
  output logic       o_busy
);

  // Elaboration-time GF multiply, used only to build the generator table.
  function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1D : 8'h00);
    end
    return acc;
  endfunction

  // g(x) = prod (x + alpha^i), i=0..NSYM-1; returns g_0..g_{NSYM-1} (g_NSYM = 1 is implied).
  function automatic logic [8*NSYM-1:0] f_gen_poly();
    logic [8*(NSYM+1)-1:0] g;
    logic [7:0]            root;
    g        = '0;
    g[7:0]   = 8'h01;
    root     = 8'h01;
    for (int i = 0; i < NSYM; i++) begin
      for (int j = i + 1; j > 0; j--)
        g[j*8 +: 8] = g[(j-1)*8 +: 8] ^ f_gmul(g[j*8 +: 8], root);
      g[7:0] = f_gmul(g[7:0], root);
      root   = f_gmul(root, 8'h02);
    end
    return g[8*NSYM-1:0];
  endfunction

  localparam logic [8*NSYM-1:0] GEN       = f_gen_poly();
  localparam logic [7:0]        K_CNT     = 8'(K);
  localparam logic [7:0]        NSYM_LAST = 8'(NSYM - 1);

  typedef enum logic [1:0] {S_IDLE, S_MSG, S_PAR} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_p [NSYM];
  logic [7:0] r_cnt;
  logic [7:0] r_dout;
  logic       r_dout_valid;
  logic       r_dout_sop;
  logic       r_dout_eop;
  logic       r_parity_flag;
  logic       r_abort;

  logic       w_accept;
  logic       w_restart;
  logic       w_msg_step;
  logic       w_msg_done;
  logic       w_par_done;
  logic [7:0] w_fb;
  logic [7:0] w_msg_cnt;
  logic [7:0] w_prod  [NSYM];
  logic [7:0] w_p_upd [NSYM];

  assign o_din_ready = (r_state != S_PAR);
  assign o_busy      = (r_state != S_IDLE);
  assign w_accept    = i_din_valid && o_din_ready;
  // A start with an accept always begins a fresh codeword, from IDLE or mid-message.
  assign w_restart   = w_accept && i_start;
  assign w_msg_step  = w_restart || (w_accept && (r_state == S_MSG));
  // On a fresh codeword the LFSR is treated as already cleared.
  assign w_fb        = i_din ^ (w_restart ? 8'h00 : r_p[NSYM-1]);
  assign w_msg_cnt   = w_restart ? 8'd1 : (r_cnt + 8'd1);
  assign w_msg_done  = (w_msg_cnt == K_CNT);
  assign w_par_done  = (r_cnt == NSYM_LAST);

  for (genvar gi = 0; gi < NSYM; gi++) begin : g_mul
    gf256_mul u_mul (
      .i_a (w_fb),
      .i_b (GEN[gi*8 +: 8]),
      .o_p (w_prod[gi])
    );
  end

  // LFSR division step: shift up and add fb * g_i into every tap.
  always_comb begin
    w_p_upd[0] = w_prod[0];
    for (int i = 1; i < NSYM; i++)
      w_p_upd[i] = (w_restart ? 8'h00 : r_p[i-1]) ^ w_prod[i];
  end

  // Next-state logic: message phase ends on the K-th symbol, parity phase after NSYM shifts.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_MSG: begin
        if (w_msg_step) w_state_nxt = w_msg_done ? S_PAR : S_MSG;
      end
      S_PAR: begin
        if (w_par_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Datapath: LFSR update, symbol counter and registered output stream.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < NSYM; i++) r_p[i] <= 8'h00;
      r_cnt         <= 8'd0;
      r_dout        <= 8'h00;
      r_dout_valid  <= 1'b0;
      r_dout_sop    <= 1'b0;
      r_dout_eop    <= 1'b0;
      r_parity_flag <= 1'b0;
      r_abort       <= 1'b0;
    end else begin
      r_dout_valid  <= 1'b0;
      r_dout_sop    <= 1'b0;
      r_dout_eop    <= 1'b0;
      r_parity_flag <= 1'b0;
      r_abort       <= 1'b0;
      case (r_state)
        S_IDLE, S_MSG: begin
          if (w_msg_step) begin
            for (int i = 0; i < NSYM; i++) r_p[i] <= w_p_upd[i];
            // The counter is reused to count parity shifts, so it restarts at zero.
            r_cnt        <= w_msg_done ? 8'd0 : w_msg_cnt;
            r_dout       <= i_din;
            r_dout_valid <= 1'b1;
            r_dout_sop   <= w_restart;
            r_abort      <= w_restart && (r_state == S_MSG);
          end
        end
        S_PAR: begin
          r_dout <= r_p[NSYM-1];
          for (int i = 1; i < NSYM; i++) r_p[i] <= r_p[i-1];
          r_p[0]        <= 8'h00;
          r_dout_valid  <= 1'b1;
          r_parity_flag <= 1'b1;
          r_dout_eop    <= w_par_done;
          r_cnt         <= w_par_done ? 8'd0 : (r_cnt + 8'd1);
        end
        default: ;
      endcase
    end
  end

  assign o_dout        = r_dout;
  assign o_dout_valid  = r_dout_valid;
  assign o_dout_sop    = r_dout_sop;
  assign o_dout_eop    = r_dout_eop;
  assign o_parity_flag = r_parity_flag;
  assign o_abort       = r_abort;

endmodule

// File: doc/rs_encoder_lfsr.md
Name: rs_encoder_lfsr

Overview:
- Systematic byte-serial Reed-Solomon encoder over GF(2^8), primitive polynomial 0x11D, alpha = 0x02.
- Generator g(x) = prod_{i=0..NSYM-1} (x + alpha^i), consistent with the syndrome and Euclidean decoder chain.
- Passes K message symbols through unchanged, then emits NSYM parity symbols computed by a division LFSR.
- Sits at the transmit end of the codec; its codewords feed the decoder's syndrome stage directly.

Parameters:
K, 239, message symbols per codeword (1..255-NSYM)
NSYM, 16, parity symbols per codeword (2t); even, 2..32
Generator coefficients g_0..g_{NSYM-1} are a constant table derived from NSYM at elaboration; g_NSYM = 1 implied.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset
din  in  8  message symbol, highest-degree coefficient first
din_valid  in  1  din carries a symbol this cycle
start  in  1  qualifies first symbol of a codeword; sampled only with din_valid
din_ready  out  1  encoder accepts a symbol this cycle
dout  out  8  codeword symbol (registered)
dout_valid  out  1  dout valid
dout_sop  out  1  first symbol of codeword
dout_eop  out  1  last parity symbol
parity_flag  out  1  dout is a parity symbol
abort  out  1  one-cycle pulse: codeword dropped by restart
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-low. On reset, all outputs go to 0 except din_ready, which goes to 1. LFSR registers p[0..NSYM-1] go to 0, the counter to 0, and state to IDLE.
- Accept: a symbol is accepted when din_valid && din_ready.
- States: IDLE, MSG, PAR.
- IDLE:
  - An accept with start=1 clears the LFSR, loads the first symbol into the LFSR, sets cnt=1 and moves to MSG.
  - An accept with start=0 is discarded, with no output.
- MSG, per accept:
  - fb = din ^ p[NSYM-1].
  - p[i] <= p[i-1] ^ gmul(fb, g_i); p[0] <= gmul(fb, g_0).
  - cnt increments.
  - When cnt reaches K, the next state is PAR and din_ready drops the following cycle.
- MSG, stalls: din_valid=0 holds all state, and dout_valid=0 that cycle.
- Output timing: dout registers the accepted din with 1-cycle latency. dout_sop marks the first symbol. parity_flag=0 during message symbols.
- PAR:
  - din_ready=0.
  - Shift out for exactly NSYM consecutive cycles: dout <= p[NSYM-1], p[i] <= p[i-1], p[0] <= 0, parity_flag=1.
  - The first parity symbol appears the cycle after the last message symbol on dout, with no gap.
  - dout_eop is asserted with the final parity symbol.
  - After the final shift, state goes to IDLE and din_ready=1 the next cycle.
- Back-to-back codewords: total throughput is K+NSYM cycles per codeword. A start accepted on the first cycle din_ready is high again produces a contiguous output stream.
- Restart in MSG: start=1 with an accept abandons the current codeword. Required response:
  - pulse abort;
  - no parity is emitted for the abandoned codeword;
  - the new symbol is treated as the first symbol (sop, cnt=1, LFSR reinitialised).
  - Already-output message symbols are not retracted.
- Start during PAR: ignored, since din_ready=0.
- GF multiply: gmul(a,b) is the combinational GF(2^8) product mod 0x11D, instantiated from the codebase multiplier. Addition is XOR.
- Counter: 8-bit. No wrap occurs, because K <= 253 is enforced by the parameter range.
- Reset mid-operation: asynchronous clear to the reset state. No partial codeword completes afterward.
- Invariant: every complete codeword c(x) satisfies c(alpha^i)=0 for i=0..NSYM-1.

Test Plan:
1. Reset, then K=239 zero symbols with start on the first: 255 outputs all 0x00. sop on output 1, parity_flag on outputs 240-255, eop on output 255, din_ready low for 16 cycles.
2. Message of 238 zeros followed by 0x01: parity symbols equal g_15, g_14, ..., g_0 in order. For the default generator the first parity symbol equals g_15 = XOR of alpha^0..alpha^15 = 0x3B (checked against the software table).
3. Random messages (1000 codewords, random din_valid gaps ~30%): all 16 syndromes at alpha^0..alpha^15 are zero, message bytes pass through bit-exact, and parity matches the C reference encoder.
4. Restart: start reasserted on message symbol 100 → abort pulses one cycle, no parity for the first codeword, and the second codeword is complete and syndrome-clean.
5. Asynchronous reset dropped during parity symbol 5 → all outputs zero and din_ready=1 immediately. The next codeword encodes correctly.
6. Back-to-back: 4 codewords with din_valid held high whenever din_ready=1 → dout_valid stays high continuously for 4×255 cycles, with exactly 4 sop and 4 eop.
